// File: rtl/linebuf_sched.sv
// Ping-pong sprite line buffer: one bank is scanned out and cleared behind the beam
// while the other is drawn. Define LINEBUF_PRIO_EN for first-writer-wins drawing.
module linebuf_sched #(
    parameter int HTOTAL = 396,
    parameter int DW     = 8,
    parameter int AW     = 9
) (
    input  logic          PCLK,
    input  logic          RESETn,
    input  logic [8:0]    HPOS,
    input  logic          VBLK,
    input  logic          WREQ,
    input  logic [AW-1:0] WADR,
    input  logic [DW-1:0] WDAT,
    output logic          WACK,
    output logic [DW-1:0] ODAT,
    output logic          BANK,
    output logic          LSTART,
    output logic          BUSY
);
    localparam int         DEPTH   = 1 << AW;
    localparam logic [8:0] HLAST   = 9'(HTOTAL - 1);
    localparam logic [8:0] HPENULT = 9'(HTOTAL - 2);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;
    logic          wack_q, wack_d;
    logic          lstart_q, lstart_d;
    logic [DW-1:0] odat_q, odat_d;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    logic [AW-1:0] haddr;
    logic [DW-1:0] disp_rd;
    logic          accept;
    logic          draw_we;
    logic [AW-1:0] draw_wa;
    logic [DW-1:0] draw_wd;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;

    assign haddr   = AW'(HPOS);
    // Display bank is the one not being drawn.
    assign disp_rd = bank_q ? mem0[haddr] : mem1[haddr];

`ifdef LINEBUF_PRIO_EN
    logic          vld_p0_q;
    logic [AW-1:0] adr_p0_q;
    logic [DW-1:0] dat_p0_q;
    logic [DW-1:0] old_p0_q;
    logic [DW-1:0] draw_rd;

    assign draw_rd = bank_q ? mem1[WADR] : mem0[WADR];

    // Acceptance window excludes the last two pixels so read and write share one bank.
    always_comb begin
        accept  = (state_q == ST_RUN) && WREQ && (HPOS != HLAST) && (HPOS != HPENULT)
                  && !vld_p0_q && !wack_q;
        draw_we = vld_p0_q && (old_p0_q == '0) && (dat_p0_q != '0);
        draw_wa = adr_p0_q;
        draw_wd = dat_p0_q;
        wack_d  = vld_p0_q;
    end

    always_ff @(posedge PCLK or negedge RESETn) begin
        if (!RESETn) begin
            vld_p0_q <= 1'b0;
        end else begin
            vld_p0_q <= accept;
        end
    end

    // p0: capture request and the word currently stored at its address
    always_ff @(posedge PCLK) begin
        if (accept) begin
            adr_p0_q <= WADR;
            dat_p0_q <= WDAT;
            old_p0_q <= draw_rd;
        end
    end
`else
    always_comb begin
        accept  = (state_q == ST_RUN) && WREQ && (HPOS != HLAST);
        draw_we = accept && (WDAT != '0);
        draw_wa = WADR;
        draw_wd = WDAT;
        wack_d  = accept;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        lstart_d = 1'b0;
        odat_d   = '0;
        we0      = 1'b0;
        wa0      = haddr;
        wd0      = '0;
        we1      = 1'b0;
        wa1      = haddr;
        wd1      = '0;
        if (state_q == ST_INIT) begin
            we0   = 1'b1;
            wa0   = cnt_q;
            we1   = 1'b1;
            wa1   = cnt_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end else begin
            odat_d   = VBLK ? '0 : disp_rd;
            lstart_d = (HPOS == HLAST);
            if (HPOS == HLAST) begin
                bank_d = ~bank_q;
            end
            // Display bank takes the read-then-clear write, draw bank takes sprite writes.
            if (bank_q) begin
                we0 = 1'b1;
                we1 = draw_we;
                wa1 = draw_wa;
                wd1 = draw_wd;
            end else begin
                we1 = 1'b1;
                we0 = draw_we;
                wa0 = draw_wa;
                wd0 = draw_wd;
            end
        end
    end

    always_ff @(posedge PCLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            bank_q   <= 1'b0;
            wack_q   <= 1'b0;
            lstart_q <= 1'b0;
            odat_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            wack_q   <= wack_d;
            lstart_q <= lstart_d;
            odat_q   <= odat_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (we0) begin
            mem0[wa0] <= wd0;
        end
        if (we1) begin
            mem1[wa1] <= wd1;
        end
    end

    assign WACK   = wack_q;
    assign ODAT   = odat_q;
    assign BANK   = bank_q;
    assign LSTART = lstart_q;
    assign BUSY   = (state_q == ST_INIT);

endmodule

// File: tb/tb_linebuf_sched.sv
// Self-checking bench for linebuf_sched against a line-level behavioural model.
module tb_linebuf_sched;
    localparam int HT = 396;
`ifdef LINEBUF_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam int EXP_LAT = PRIO ? 2 : 1;

    logic       PCLK;
    logic       RESETn;
    logic [8:0] HPOS;
    logic       VBLK;
    logic       WREQ;
    logic [8:0] WADR;
    logic [7:0] WDAT;
    logic       WACK;
    logic [7:0] ODAT;
    logic       BANK;
    logic       LSTART;
    logic       BUSY;

    linebuf_sched dut (
        .PCLK  (PCLK),
        .RESETn(RESETn),
        .HPOS  (HPOS),
        .VBLK  (VBLK),
        .WREQ  (WREQ),
        .WADR  (WADR),
        .WDAT  (WDAT),
        .WACK  (WACK),
        .ODAT  (ODAT),
        .BANK  (BANK),
        .LSTART(LSTART),
        .BUSY  (BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int hcnt   = 0;

    // Reference model: two line images, the draw index, init progress, write hold-off.
    logic [7:0] lb [2][512];
    bit         mbank;
    int         init_left;
    int         hold;
    logic [7:0] e_odat;
    bit         e_wack, e_lstart, e_busy;

    task automatic model_reset();
        mbank = 1'b0; init_left = 512; hold = 0;
        e_odat = 8'h00; e_wack = 1'b0; e_lstart = 1'b0; e_busy = 1'b1;
    endtask

    task automatic model_edge();
        int h;
        int disp;
        h = int'(HPOS);
        disp = mbank ? 0 : 1;
        if (!RESETn) return;
        if (init_left > 0) begin
            lb[0][512 - init_left] = 8'h00;
            lb[1][512 - init_left] = 8'h00;
            init_left--;
            e_odat = 8'h00; e_wack = 1'b0; e_lstart = 1'b0; e_busy = (init_left > 0);
            return;
        end
        e_busy = 1'b0;
        e_odat = VBLK ? 8'h00 : lb[disp][h];
        lb[disp][h] = 8'h00;
        e_wack = 1'b0;
        if (PRIO) begin
            if (hold > 0) begin
                e_wack = (hold == 2);
                hold--;
            end else if (WREQ && h != HT - 1 && h != HT - 2) begin
                if (lb[mbank][WADR] == 8'h00 && WDAT != 8'h00) lb[mbank][WADR] = WDAT;
                hold = 2;
            end
        end else if (WREQ && h != HT - 1) begin
            if (WDAT != 8'h00) lb[mbank][WADR] = WDAT;
            e_wack = 1'b1;
        end
        e_lstart = (h == HT - 1);
        if (h == HT - 1) mbank = ~mbank;
    endtask

    // One pixel clock: model consumes the driven inputs, then the free-running HPOS advances.
    task automatic tick();
        model_edge();
        @(posedge PCLK);
        #1;
        hcnt = (hcnt + 1) % HT;
        HPOS = 9'(hcnt);
        if (WACK) WREQ = 1'b0;
    endtask

    task automatic goto_h(input int h);
        for (int i = 0; i < 400; i++) begin
            if (hcnt == h) break;
            tick();
        end
    endtask

    task automatic send(input int adr, input int dat, output int lat);
        WREQ = 1'b1; WADR = 9'(adr); WDAT = 8'(dat);
        lat = 0;
        while (WACK !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        WREQ = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RESETn = 1'b0; WREQ = 1'b0; VBLK = 1'b0; WADR = '0; WDAT = '0;
        hcnt = 0; HPOS = '0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", BUSY); end
        checks++; if (BANK !== 1'b0) begin errors++; $display("FAIL rst_bank got %b want 0", BANK); end
        checks++; if (WACK !== 1'b0) begin errors++; $display("FAIL rst_wack got %b want 0", WACK); end
        checks++; if (ODAT !== 8'h00) begin errors++; $display("FAIL rst_odat got %h want 00", ODAT); end
        checks++; if (LSTART !== 1'b0) begin errors++; $display("FAIL rst_lstart got %b want 0", LSTART); end
        RESETn = 1'b1;
        WREQ = 1'b1; WADR = 9'd7; WDAT = 8'h99;
        for (int i = 1; i <= 520; i++) begin
            tick();
            checks++;
            if (BUSY !== (i < 512)) begin
                errors++; $display("FAIL init_busy cyc %0d got %b want %b", i, BUSY, (i < 512));
            end
            if (i <= 512) begin
                checks++;
                if (WACK !== 1'b0) begin errors++; $display("FAIL init_wack cyc %0d got %b want 0", i, WACK); end
                checks++;
                if (ODAT !== 8'h00) begin errors++; $display("FAIL init_odat cyc %0d got %h want 00", i, ODAT); end
            end
        end
    endtask

    task automatic test_write_scan();
        int lat;
        bit b;
        goto_h(5);
        b = mbank;
        send(10, 8'h3C, lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL ws_lat got %0d want %0d", lat, EXP_LAT); end
        goto_h(HT - 1);
        tick();
        checks++; if (LSTART !== 1'b1) begin errors++; $display("FAIL ws_lstart got %b want 1", LSTART); end
        checks++; if (BANK !== ~b) begin errors++; $display("FAIL ws_bank got %b want %b", BANK, ~b); end
        tick();
        checks++; if (LSTART !== 1'b0) begin errors++; $display("FAIL ws_lstart_end got %b want 0", LSTART); end
        goto_h(10);
        tick();
        checks++; if (ODAT !== 8'h3C) begin errors++; $display("FAIL ws_scan got %h want 3c", ODAT); end
        goto_h(HT - 1); tick();
        goto_h(HT - 1); tick();
        checks++; if (BANK !== ~b) begin errors++; $display("FAIL ws_bank3 got %b want %b", BANK, ~b); end
        goto_h(10);
        tick();
        checks++; if (ODAT !== 8'h00) begin errors++; $display("FAIL ws_cleared got %h want 00", ODAT); end
    endtask

    task automatic test_swap_pending();
        int lat;
        bit b;
        tick();
        goto_h(HT - 1);
        b = mbank;
        WREQ = 1'b1; WADR = 9'd40; WDAT = 8'h5A;
        tick();
        checks++; if (WACK !== 1'b0) begin errors++; $display("FAIL sw_wack_swap got %b want 0", WACK); end
        checks++; if (BANK !== ~b) begin errors++; $display("FAIL sw_bank got %b want %b", BANK, ~b); end
        lat = 0;
        while (WACK !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        WREQ = 1'b0;
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL sw_lat got %0d want %0d", lat, EXP_LAT); end
        goto_h(HT - 1); tick();
        goto_h(40);
        tick();
        checks++; if (ODAT !== 8'h5A) begin errors++; $display("FAIL sw_scan got %h want 5a", ODAT); end
    endtask

    task automatic test_transparent_vblank();
        int lat;
        goto_h(5);
        send(20, 8'h11, lat);
        send(20, 8'h00, lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL tr_lat got %0d want %0d", lat, EXP_LAT); end
        send(21, 8'h22, lat);
        goto_h(HT - 1); tick();
        goto_h(20);
        tick();
        checks++; if (ODAT !== 8'h11) begin errors++; $display("FAIL tr_scan got %h want 11", ODAT); end
        VBLK = 1'b1;
        tick();
        checks++; if (ODAT !== 8'h00) begin errors++; $display("FAIL tr_vblk got %h want 00", ODAT); end
        VBLK = 1'b0;
        goto_h(HT - 1); tick();
        goto_h(HT - 1); tick();
        goto_h(21);
        tick();
        checks++; if (ODAT !== 8'h00) begin errors++; $display("FAIL tr_vblk_clear got %h want 00", ODAT); end
    endtask

    task automatic test_priority();
        int lat;
        goto_h(5);
        send(30, 8'h05, lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL pr_lat1 got %0d want %0d", lat, EXP_LAT); end
        send(30, 8'h07, lat);
        checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL pr_lat2 got %0d want %0d", lat, EXP_LAT); end
        goto_h(HT - 1); tick();
        goto_h(30);
        tick();
        checks++;
        if (ODAT !== (PRIO ? 8'h05 : 8'h07)) begin
            errors++; $display("FAIL pr_scan got %h want %h", ODAT, (PRIO ? 8'h05 : 8'h07));
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            VBLK = ($urandom_range(0, 7) == 0);
            if (!WREQ && $urandom_range(0, 1) == 1) begin
                WREQ = 1'b1;
                WADR = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 511));
                WDAT = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            tick();
            checks++; if (ODAT !== e_odat) begin errors++; $display("FAIL rnd_odat cyc %0d got %h want %h", i, ODAT, e_odat); end
            checks++; if (WACK !== e_wack) begin errors++; $display("FAIL rnd_wack cyc %0d got %b want %b", i, WACK, e_wack); end
            checks++; if (LSTART !== e_lstart) begin errors++; $display("FAIL rnd_lstart cyc %0d got %b want %b", i, LSTART, e_lstart); end
            checks++; if (BANK !== mbank) begin errors++; $display("FAIL rnd_bank cyc %0d got %b want %b", i, BANK, mbank); end
            checks++; if (BUSY !== e_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", i, BUSY, e_busy); end
        end
        VBLK = 1'b0;
    endtask

    task automatic test_reset_mid();
        #3;
        RESETn = 1'b0;
        model_reset();
        #1;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mr_busy got %b want 1", BUSY); end
        checks++; if (BANK !== 1'b0) begin errors++; $display("FAIL mr_bank got %b want 0", BANK); end
        checks++; if (WACK !== 1'b0) begin errors++; $display("FAIL mr_wack got %b want 0", WACK); end
        checks++; if (ODAT !== 8'h00) begin errors++; $display("FAIL mr_odat got %h want 00", ODAT); end
        @(posedge PCLK);
        #1;
        RESETn = 1'b1;
        WREQ = 1'b1; WADR = 9'd3; WDAT = 8'h44;
        for (int i = 1; i <= 515; i++) begin
            tick();
            checks++; if (BUSY !== e_busy) begin errors++; $display("FAIL mr_init_busy cyc %0d got %b want %b", i, BUSY, e_busy); end
            checks++; if (WACK !== e_wack) begin errors++; $display("FAIL mr_init_wack cyc %0d got %b want %b", i, WACK, e_wack); end
            checks++; if (ODAT !== e_odat) begin errors++; $display("FAIL mr_init_odat cyc %0d got %h want %h", i, ODAT, e_odat); end
        end
    endtask

    initial begin
        test_reset();
        test_write_scan();
        test_swap_pending();
        test_transparent_vblank();
        test_priority();
        test_random(1600);
        test_reset_mid();
        test_random(900);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
